// File: rtl/qdiv_pipe_radix.sv
// ---------------------------------------------------------------------------
// qdiv_pipe_radix
//   Multi-cycle signed-magnitude Q-format divider using a restoring
//   algorithm that resolves R quotient bits per clock.
//   Computes M = floor((|a| << Q) / |b|), truncated toward zero.
//
// Parameters:
//   Q  fractional bits
//   N  word width (bit N-1 = sign, N-2:0 = magnitude)
//   R  quotient bits per clock (1, 2 or 4)
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_dividend      signed-magnitude dividend
//   i_divisor       signed-magnitude divisor
//   i_start         start request, sampled only while idle
//   o_quotient_out  signed-magnitude quotient, held until the next result
//   o_complete      1 = idle / result valid, 0 = busy
//   o_done          one-cycle pulse when a result is written
//   o_overflow      quotient magnitude does not fit N-1 bits (or divide-by-zero)
//   o_div_by_zero   divisor magnitude was zero
//
// Build option:
//   QDIV_SATURATE_EN  when defined, an overflowing magnitude is clamped to
//                     all ones; otherwise the low N-1 quotient bits are kept.
// ---------------------------------------------------------------------------
module qdiv_pipe_radix #(
   parameter int Q = 15,
   parameter int N = 32,
   parameter int R = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   input  logic         i_start,
   output logic [N-1:0] o_quotient_out,
   output logic         o_complete,
   output logic         o_done,
   output logic         o_overflow,
   output logic         o_div_by_zero
);

   localparam int W  = N - 1 + Q;          // quotient bits to resolve
   localparam int C  = (W + R - 1) / R;    // RUN cycles
   localparam int P  = C * R;              // padded work register width
   localparam int CW = $clog2(C + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e        state_q;
   logic [P-1:0]  work_q, work_d;   // numerator bits leave at the MSB, quotient bits enter at the LSB
   logic [N-1:0]  rem_q, rem_d;     // one bit wider than the divisor to hold the shifted remainder
   logic [N-2:0]  dvsr_q;
   logic          sign_q;
   logic          zero_div_q;
   logic [CW-1:0] cnt_q;

   logic [N-1:0]  quo_q;
   logic          complete_q, done_q, ovf_q, dbz_q;

   // R restoring steps per clock, MSB first.
   // NOTE: blocking assignments here chain the R steps within one cycle; every
   // combinational output gets a default first so no latch is inferred.
   always_comb begin
      work_d = work_q;
      rem_d  = rem_q;
      for (int s = 0; s < R; s++) begin
         rem_d  = {rem_d[N-2:0], work_d[P-1]};
         work_d = {work_d[P-2:0], 1'b0};
         if (rem_d >= {1'b0, dvsr_q}) begin
            rem_d     = rem_d - {1'b0, dvsr_q};
            work_d[0] = 1'b1;
         end
      end
   end

   // Result formatting from the finished quotient register.
   logic [W-1:0] m;
   logic         ovf_calc;
   logic [N-2:0] mag;
   logic         sign_out;

   always_comb begin
      m        = work_q[W-1:0];
      ovf_calc = |m[W-1:N-1];
`ifdef QDIV_SATURATE_EN
      mag      = (zero_div_q | ovf_calc) ? '1 : m[N-2:0];
`else
      mag      = zero_div_q ? '1 : m[N-2:0];
`endif
      // No negative zero.
      sign_out = sign_q & (mag != '0);
   end

   // NOTE: sequential state uses non-blocking assignments only, and the
   // synchronous reset clears the working registers along with the outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         work_q     <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         sign_q     <= 1'b0;
         zero_div_q <= 1'b0;
         cnt_q      <= '0;
         quo_q      <= '0;
         complete_q <= 1'b1;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  work_q     <= P'(i_dividend[N-2:0]) << Q;
                  rem_q      <= '0;
                  dvsr_q     <= i_divisor[N-2:0];
                  sign_q     <= i_dividend[N-1] ^ i_divisor[N-1];
                  zero_div_q <= (i_divisor[N-2:0] == '0);
                  cnt_q      <= '0;
                  ovf_q      <= 1'b0;
                  dbz_q      <= 1'b0;
                  complete_q <= 1'b0;
                  state_q    <= (i_divisor[N-2:0] == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               work_q <= work_d;
               rem_q  <= rem_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(C - 1)) state_q <= S_DONE;
            end
            S_DONE: begin
               quo_q      <= {sign_out, mag};
               ovf_q      <= zero_div_q | ovf_calc;
               dbz_q      <= zero_div_q;
               done_q     <= 1'b1;
               complete_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_quotient_out = quo_q;
   assign o_complete     = complete_q;
   assign o_done         = done_q;
   assign o_overflow     = ovf_q;
   assign o_div_by_zero  = dbz_q;

endmodule

// File: tb/tb_qdiv_pipe_radix.sv
// ---------------------------------------------------------------------------
// tb_qdiv_pipe_radix
//   Directed bench for qdiv_pipe_radix with N=32, Q=15. Three instances
//   (R=1, R=2, R=4) share clock, reset and operands; each has its own start.
//   Index 0 -> R=1, 1 -> R=2, 2 -> R=4.
// ---------------------------------------------------------------------------
module tb_qdiv_pipe_radix;

   logic        clk;
   logic        rst;
   logic [31:0] dividend, divisor;
   logic [2:0]  start;

   logic [31:0] quo1, quo2, quo4;
   logic        cmp1, cmp2, cmp4, dn1, dn2, dn4, ov1, ov2, ov4, dz1, dz2, dz4;

   logic [31:0] quo_v [3];
   logic [2:0]  complete_v, done_v, ovf_v, dbz_v;

   int n_cmp = 0;
   int n_err = 0;
   int exp_lat [3] = '{47, 24, 13};

   assign quo_v[0]   = quo1;
   assign quo_v[1]   = quo2;
   assign quo_v[2]   = quo4;
   assign complete_v = {cmp4, cmp2, cmp1};
   assign done_v     = {dn4, dn2, dn1};
   assign ovf_v      = {ov4, ov2, ov1};
   assign dbz_v      = {dz4, dz2, dz1};

   qdiv_pipe_radix #(.Q(15), .N(32), .R(1)) u_r1 (
      .i_clk(clk), .i_rst(rst), .i_dividend(dividend), .i_divisor(divisor),
      .i_start(start[0]), .o_quotient_out(quo1), .o_complete(cmp1),
      .o_done(dn1), .o_overflow(ov1), .o_div_by_zero(dz1));

   qdiv_pipe_radix #(.Q(15), .N(32), .R(2)) u_r2 (
      .i_clk(clk), .i_rst(rst), .i_dividend(dividend), .i_divisor(divisor),
      .i_start(start[1]), .o_quotient_out(quo2), .o_complete(cmp2),
      .o_done(dn2), .o_overflow(ov2), .o_div_by_zero(dz2));

   qdiv_pipe_radix #(.Q(15), .N(32), .R(4)) u_r4 (
      .i_clk(clk), .i_rst(rst), .i_dividend(dividend), .i_divisor(divisor),
      .i_start(start[2]), .o_quotient_out(quo4), .o_complete(cmp4),
      .o_done(dn4), .o_overflow(ov4), .o_div_by_zero(dz4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one division on instance id and waits for its done pulse.
   // lat = number of rising edges after the accepting edge until o_done is seen.
   // When poke is set, a second start with other operands is pulsed mid-RUN.
   task automatic do_div(input int id, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, output int lat, output bit to);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      start[id] = 1'b1;
      @(posedge clk);
      lat = 0;
      to  = 1'b1;
      @(negedge clk);
      start[id] = 1'b0;
      for (int c = 1; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (done_v[id]) begin
            lat = c;
            to  = 1'b0;
            break;
         end
         if (poke && c == 4) begin
            dividend  = 32'h7FFF_FFFF;
            divisor   = 32'h0000_0001;
            start[id] = 1'b1;
         end
         if (c == 6) start[id] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = '0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (complete_v[i] !== 1'b1) begin n_err++; $display("FAIL reset_complete[%0d]: got %b want 1", i, complete_v[i]); end
         n_cmp++; if (done_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_v[i]); end
         n_cmp++; if (quo_v[i] !== 32'h0) begin n_err++; $display("FAIL reset_quo[%0d]: got %h want 00000000", i, quo_v[i]); end
         n_cmp++; if (ovf_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_ovf[%0d]: got %b want 0", i, ovf_v[i]); end
         n_cmp++; if (dbz_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_dbz[%0d]: got %b want 0", i, dbz_v[i]); end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Check one finished result (called right after the done pulse is seen).
   task automatic test_result(input string name, input int id, input int lat, input bit to,
                              input logic [31:0] q, input logic ov, input logic dz, input int want_lat);
      n_cmp++; if (to) begin n_err++; $display("FAIL %s_timeout[%0d]: no done within budget", name, id); end
      n_cmp++; if (lat != want_lat) begin n_err++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, id, lat, want_lat); end
      n_cmp++; if (quo_v[id] !== q) begin n_err++; $display("FAIL %s_quo[%0d]: got %h want %h", name, id, quo_v[id], q); end
      n_cmp++; if (ovf_v[id] !== ov) begin n_err++; $display("FAIL %s_ovf[%0d]: got %b want %b", name, id, ovf_v[id], ov); end
      n_cmp++; if (dbz_v[id] !== dz) begin n_err++; $display("FAIL %s_dbz[%0d]: got %b want %b", name, id, dbz_v[id], dz); end
      n_cmp++; if (complete_v[id] !== 1'b1) begin n_err++; $display("FAIL %s_complete[%0d]: got %b want 1", name, id, complete_v[id]); end
   endtask

   task automatic test_basic_r1();
      int lat; bit to;
      do_div(0, 32'h0001_8000, 32'h0001_0000, 1'b0, lat, to);   // 3.0 / 2.0 = 1.5
      test_result("basic", 0, lat, to, 32'h0000_C000, 1'b0, 1'b0, 47);
      @(posedge clk); #1;
      n_cmp++; if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done_v[0]); end
   endtask

   task automatic test_radix();
      int lat; bit to;
      for (int i = 1; i < 3; i++) begin
         do_div(i, 32'h8001_8000, 32'h0001_0000, 1'b0, lat, to); // -3.0 / 2.0 = -1.5
         test_result("radix", i, lat, to, 32'h8000_C000, 1'b0, 1'b0, exp_lat[i]);
      end
   endtask

   task automatic test_truncation();
      int lat; bit to;
      for (int i = 0; i < 3; i++) begin
         do_div(i, 32'h0000_8000, 32'h0001_8000, 1'b0, lat, to); // 1.0 / 3.0
         test_result("third", i, lat, to, 32'h0000_2AAA, 1'b0, 1'b0, exp_lat[i]);
      end
      // Tiny negative result truncates to zero; sign must not survive.
      do_div(2, 32'h8000_0001, 32'h0001_0000, 1'b0, lat, to);
      test_result("negzero", 2, lat, to, 32'h0000_0000, 1'b0, 1'b0, 13);
   endtask

   task automatic test_div_by_zero();
      int lat; bit to;
      // Negative zero divisor: sign = 0 ^ 1, magnitude all ones; done on the edge after acceptance.
      do_div(0, 32'h0000_8000, 32'h8000_0000, 1'b0, lat, to);
      test_result("dbz", 0, lat, to, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
      do_div(2, 32'h0000_8000, 32'h0000_0000, 1'b0, lat, to);
      test_result("dbz_pos", 2, lat, to, 32'h7FFF_FFFF, 1'b1, 1'b1, 1);
   endtask

   task automatic test_overflow();
      int lat; bit to;
      logic [31:0] want;
`ifdef QDIV_SATURATE_EN
      want = 32'h7FFF_FFFF;
`else
      want = 32'h7FFF_8000;
`endif
      do_div(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, to);
      test_result("ovf", 0, lat, to, want, 1'b1, 1'b0, 47);
   endtask

   task automatic test_busy_start();
      int lat; bit to;
      // Overflowing operands poked mid-RUN must be ignored.
      do_div(1, 32'h0001_8000, 32'h0001_0000, 1'b1, lat, to);
      test_result("busy", 1, lat, to, 32'h0000_C000, 1'b0, 1'b0, 24);
   endtask

   task automatic test_back_to_back();
      int lat; bit to;
      do_div(2, 32'h0001_8000, 32'h0001_0000, 1'b0, lat, to);
      test_result("b2b_first", 2, lat, to, 32'h0000_C000, 1'b0, 1'b0, 13);
      // Still inside the done cycle: hold start high for the next operation.
      dividend = 32'h0000_8000;
      divisor  = 32'h0001_8000;
      start[2] = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (complete_v[2] !== 1'b0) begin n_err++; $display("FAIL b2b_accept: complete got %b want 0", complete_v[2]); end
      n_cmp++; if (quo_v[2] !== 32'h0000_C000) begin n_err++; $display("FAIL b2b_hold: quo got %h want 0000c000", quo_v[2]); end
      @(negedge clk);
      start[2] = 1'b0;
      lat = 0;
      to  = 1'b1;
      for (int c = 1; c < 100; c++) begin
         @(posedge clk); #1;
         if (done_v[2]) begin lat = c; to = 1'b0; break; end
      end
      test_result("b2b_second", 2, lat, to, 32'h0000_2AAA, 1'b0, 1'b0, 13);
   endtask

   task automatic test_mid_reset();
      int lat; bit to;
      // R=1 instance currently holds the overflow result (nonzero quotient).
      @(negedge clk);
      dividend = 32'h0001_8000;
      divisor  = 32'h0001_0000;
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (complete_v[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy: complete got %b want 0", complete_v[0]); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (complete_v[0] !== 1'b1) begin n_err++; $display("FAIL midrst_complete: got %b want 1", complete_v[0]); end
      n_cmp++; if (quo_v[0] !== 32'h0) begin n_err++; $display("FAIL midrst_quo: got %h want 00000000", quo_v[0]); end
      n_cmp++; if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done_v[0]); end
      n_cmp++; if (ovf_v[0] !== 1'b0 || dbz_v[0] !== 1'b0) begin n_err++; $display("FAIL midrst_flags: ovf %b dbz %b want 0 0", ovf_v[0], dbz_v[0]); end
      @(negedge clk);
      rst = 1'b0;
      // Clean operation afterwards.
      do_div(0, 32'h0001_8000, 32'h0001_0000, 1'b0, lat, to);
      test_result("after_rst", 0, lat, to, 32'h0000_C000, 1'b0, 1'b0, 47);
   endtask

   initial begin
      test_reset();
      test_basic_r1();
      test_radix();
      test_truncation();
      test_div_by_zero();
      test_overflow();
      test_busy_start();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
